// File: rtl/input_decoder_pkg.sv
// Shared definitions for the input_decoder block.
// Contents: the framing state enum, the packet delimiter words, the header
// field positions and a small header length check helper.
package input_decoder_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    TRAILER = 3'd3,
    EMIT    = 3'd4
  } state_e;

  localparam logic [31:0] PKT_START_WORD = 32'hF00BF00B;
  localparam logic [31:0] PKT_STOP_WORD  = 32'hDEADF00B;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int LEN_MSB    = 7;
  localparam int LEN_LSB    = 0;

  // A header length is usable when it names at least one and at most
  // max_len payload words.
  function automatic logic hdr_len_ok(input logic [7:0] n, input int max_len);
    return (n != 8'd0) && (int'(n) <= max_len);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering the incoming command words.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (flushes the FIFO)
//   push, wr_data     write strobe and word; ignored while full
//   pop, rd_data      read strobe; rd_data shows the oldest word (valid when !empty)
//   full, empty       occupancy flags
// A word written at one edge is visible on rd_data from the next cycle.
module sync_fifo #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A push while full is dropped even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/input_decoder.sv
// Frames START/STOP delimited packets from the command word stream, decodes
// the header and presents one complete command to the drawing engine.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   fifo_write, fifo_write_data     word push from the Avalon slave side
//   fifo_full, overflow             FIFO full flag, sticky dropped-push flag
//   clr_status                      clears overflow and err_count
//   cmd_valid, cmd_ready            command handshake
//   cmd_opcode, cmd_len, cmd_payload  decoded command
//   err_count                       discarded packets, saturating at 255
// Handshake: cmd_valid/cmd_ready transfer a command on a clock edge where both
// are high; while cmd_valid is high and cmd_ready low, cmd_opcode, cmd_len and
// cmd_payload hold steady, and cmd_valid never drops without a transfer.
module input_decoder
  import input_decoder_pkg::*;
#(
  parameter int                   DATAWIDTH   = 32,
  parameter int                   FIFO_DEPTH  = 16,
  parameter int                   MAX_PAYLOAD = 4,
  parameter logic [DATAWIDTH-1:0] START_WORD  = PKT_START_WORD,
  parameter logic [DATAWIDTH-1:0] STOP_WORD   = PKT_STOP_WORD
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              fifo_write,
  input  logic [DATAWIDTH-1:0]              fifo_write_data,
  output logic                              fifo_full,
  output logic                              overflow,
  input  logic                              clr_status,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [7:0]                        cmd_opcode,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]  cmd_len,
  output logic [MAX_PAYLOAD*DATAWIDTH-1:0]  cmd_payload,
  output logic [7:0]                        err_count
);

  localparam int LW = $clog2(MAX_PAYLOAD+1);

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [DATAWIDTH-1:0] payload_q [MAX_PAYLOAD];
  logic [DATAWIDTH-1:0] payload_d [MAX_PAYLOAD];
  logic                 overflow_q, overflow_d;
  logic [7:0]           err_q, err_d;

  logic                 fifo_empty;
  logic                 pop;
  logic [DATAWIDTH-1:0] word;
  logic [7:0]           hdr_len;
  logic                 err_pulse;

  sync_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_write),
    .wr_data (fifo_write_data),
    .pop     (pop),
    .rd_data (word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The word stream only stalls while a finished command waits downstream.
  assign pop     = !fifo_empty && (state_q != EMIT);
  assign hdr_len = word[LEN_MSB:LEN_LSB];

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    len_d     = len_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    err_pulse = 1'b0;
    case (state_q)
      HUNT: begin
        if (pop && (word == START_WORD)) state_d = HEADER;
      end
      HEADER: begin
        if (pop) begin
          opcode_d = word[OPCODE_MSB:OPCODE_LSB];
          idx_d    = '0;
          if (!hdr_len_ok(hdr_len, MAX_PAYLOAD)) begin
            err_pulse = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d = hdr_len[LW-1:0];
            // Clearing here keeps slots beyond N at zero in the emitted command.
            for (int i = 0; i < MAX_PAYLOAD; i++) payload_d[i] = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pop) begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == LW'(i)) payload_d[i] = word;
          end
          idx_d = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (pop) begin
          if (word == STOP_WORD) begin
            state_d = EMIT;
          end else begin
            // The bad trailer word is consumed; hunting resumes after it.
            err_pulse = 1'b1;
            state_d   = HUNT;
          end
        end
      end
      EMIT: begin
        if (cmd_ready) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Status: clr_status takes priority over a coincident error or drop.
  always_comb begin
    overflow_d = overflow_q;
    err_d      = err_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      err_d      = 8'd0;
    end else begin
      if (fifo_write && fifo_full)        overflow_d = 1'b1;
      if (err_pulse && (err_q != 8'hFF))  err_d      = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      opcode_q   <= 8'd0;
      len_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      err_q      <= 8'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) payload_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      for (int i = 0; i < MAX_PAYLOAD; i++) payload_q[i] <= payload_d[i];
    end
  end

  assign cmd_valid  = (state_q == EMIT);
  assign cmd_opcode = opcode_q;
  assign cmd_len    = len_q;
  assign overflow   = overflow_q;
  assign err_count  = err_q;

  always_comb begin
    cmd_payload = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      cmd_payload[i*DATAWIDTH +: DATAWIDTH] = payload_q[i];
    end
  end

endmodule

// File: tb/tb_input_decoder.sv
// Self-checking bench for input_decoder: directed packets, a full/overflow
// scenario, reset mid-packet, randomized packets and error-count saturation,
// all checked against a packet-level reference model.
module tb_input_decoder;

  localparam logic [31:0] SW = 32'hF00BF00B;
  localparam logic [31:0] PW = 32'hDEADF00B;

  logic         clk;
  logic         reset_n;
  logic         fifo_write;
  logic [31:0]  fifo_write_data;
  logic         fifo_full;
  logic         overflow;
  logic         clr_status;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode;
  logic [2:0]   cmd_len;
  logic [127:0] cmd_payload;
  logic [7:0]   err_count;

  input_decoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_full       (fifo_full),
    .overflow        (overflow),
    .clr_status      (clr_status),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_opcode      (cmd_opcode),
    .cmd_len         (cmd_len),
    .cmd_payload     (cmd_payload),
    .err_count       (err_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]   op;
    logic [2:0]   len;
    logic [127:0] pl;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [31:0] pend_q[$];
  int          exp_err = 0;

  task automatic model_err();
    if (exp_err < 255) exp_err++;
  endtask

  // Looks ahead in the accepted word stream and retires whole packets.
  task automatic model_parse();
    logic [31:0]  hdr;
    logic [127:0] pl;
    int           n;
    while (pend_q.size() > 0) begin
      if (pend_q[0] != SW) begin
        void'(pend_q.pop_front());
        continue;
      end
      if (pend_q.size() < 2) break;
      hdr = pend_q[1];
      n   = int'(hdr[7:0]);
      if (n < 1 || n > 4) begin
        model_err();
        void'(pend_q.pop_front());
        void'(pend_q.pop_front());
        continue;
      end
      if (pend_q.size() < n + 3) break;
      if (pend_q[n+2] == PW) begin
        pl = '0;
        for (int i = 0; i < n; i++) pl[i*32 +: 32] = pend_q[2+i];
        exp_q.push_back('{op: hdr[31:24], len: 3'(n), pl: pl});
      end else begin
        model_err();
      end
      repeat (n + 3) void'(pend_q.pop_front());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [138:0] held;
  logic         stall = 1'b0;
  cmd_t         mon_c;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check_eq("cmd_hold_valid", cmd_valid, 1'b1);
        check_eq("cmd_hold_data", {cmd_opcode, cmd_len, cmd_payload}, held);
      end
      if (cmd_valid && cmd_ready) begin
        check_eq("cmd_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_c = exp_q.pop_front();
          check_eq("cmd_opcode", cmd_opcode, mon_c.op);
          check_eq("cmd_len", cmd_len, mon_c.len);
          check_eq("cmd_payload", cmd_payload, mon_c.pl);
        end
      end
      stall = cmd_valid && !cmd_ready;
      held  = {cmd_opcode, cmd_len, cmd_payload};
    end
  end

  // ---------------- drivers ----------------
  logic rnd_rdy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) cmd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push without informing the model (used where drops are expected).
  task automatic push_raw(input logic [31:0] w);
    fifo_write      = 1'b1;
    fifo_write_data = w;
    @(posedge clk);
    #1;
    fifo_write = 1'b0;
  endtask

  // Push a word known to be accepted and feed it to the model.
  task automatic push_word(input logic [31:0] w);
    push_raw(w);
    pend_q.push_back(w);
    model_parse();
  endtask

  task automatic push_gap(input logic [31:0] w);
    idle($urandom_range(0, 1));
    push_word(w);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      idle(1);
      t++;
    end
    check_eq("drain_done", exp_q.size(), 0);
    idle(8);
    check_eq("err_count", err_count, exp_err);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    exp_err    = 0;
    check_eq("clr_overflow", overflow, 1'b0);
    check_eq("clr_err_count", err_count, 8'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_cmd_valid", cmd_valid, 1'b0);
    check_eq("rst_fifo_full", fifo_full, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_err_count", err_count, 8'd0);
    check_eq("rst_cmd", {cmd_opcode, cmd_len, cmd_payload}, 139'd0);
    pend_q.delete();
    exp_q.delete();
    exp_err = 0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic push_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base);
    push_word(SW);
    push_word(hdr);
    for (int i = 0; i < n; i++) push_word(base + 32'(i) * 32'h01010101);
    push_word(PW);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    fifo_write      = 1'b0;
    fifo_write_data = '0;
    clr_status      = 1'b0;
    cmd_ready       = 1'b1;
    reset_n         = 1'b0;
    idle(2);
    apply_reset();

    // 1: basic two-word command
    push_word(SW); push_word(32'h01000002); push_word(32'h11111111);
    push_word(32'h22222222); push_word(PW);
    drain();

    // 2: leading garbage ignored
    push_word(32'h12345678); push_word(SW); push_word(32'h05000001);
    push_word(32'hAAAAAAAA); push_word(PW);
    drain();

    // 3: bad trailer discarded, following packet survives
    push_word(SW); push_word(32'h02000001); push_word(32'hBBBBBBBB);
    push_word(32'hCCCCCCCC);
    push_pkt(32'h03000003, 3, 32'h30303030);
    drain();
    check_eq("t3_err_count", err_count, 8'd1);

    // 4: length out of range in both directions
    pulse_clr();
    push_word(SW); push_word(32'h07000005);
    push_word(SW); push_word(32'h07000000);
    drain();
    check_eq("t4_err_count", err_count, 8'd2);

    // 5: downstream stalled, FIFO fills and drops
    cmd_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      push_raw(SW);
      push_raw(32'h10000001 + (32'(p) << 24));
      push_raw(32'hA0000000 + 32'(p));
      push_raw(PW);
    end
    check_eq("t5_fifo_full", fifo_full, 1'b1);
    check_eq("t5_overflow", overflow, 1'b1);
    check_eq("t5_cmd_valid", cmd_valid, 1'b1);
    check_eq("t5_opcode", cmd_opcode, 8'h10);
    check_eq("t5_len", cmd_len, 3'd1);
    check_eq("t5_payload", cmd_payload, 128'hA0000000);
    idle(3);
    pulse_clr();
    check_eq("t5_full_after_clr", fifo_full, 1'b1);
    apply_reset();
    cmd_ready = 1'b1;

    // 6: reset in the middle of a payload
    push_word(SW); push_word(32'h06000004);
    push_word(32'h66666666); push_word(32'h77777777);
    apply_reset();
    push_pkt(32'h0800FF04, 4, 32'h80808080);
    drain();

    // randomized packets with random downstream backpressure
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int          kind;
      int          n;
      logic [31:0] hdr;
      logic [31:0] tr;
      kind = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) push_gap($urandom);
      push_gap(SW);
      if (kind == 2) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 255);
      else           n = $urandom_range(1, 4);
      hdr = {8'($urandom), 16'($urandom), 8'(n)};
      push_gap(hdr);
      if (kind != 2) begin
        repeat (n) push_gap($urandom);
        tr = PW;
        if (kind == 3) begin
          tr = $urandom;
          if (tr == PW) tr = tr ^ 32'h1;
        end
        push_gap(tr);
      end
      drain();
    end
    rnd_rdy = 1'b0;
    idle(2);
    cmd_ready = 1'b1;
    check_eq("rand_overflow", overflow, 1'b0);

    // error counter saturation
    pulse_clr();
    for (int k = 0; k < 260; k++) begin
      push_word(SW);
      push_word({8'($urandom), 16'h0, ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd9});
    end
    drain();
    check_eq("sat_err_count", err_count, 8'd255);
    pulse_clr();
    push_pkt(32'h0F000002, 2, 32'h0F0F0F0F);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
